// File: rtl/control_unit_pkg.sv
// Shared definitions for the ARM-subset control unit.
//   - op_e      : instruction class in Instr[27:26]
//   - alu_ctl_e : ALUControl encodings driven to the datapath ALU
//   - imm_src_e : ImmSrc encodings driven to the extend unit
//   - cond_e    : the 16 ARM condition codes in Instr[31:28]
//   - flags_t   : stored NZCV flags, MSB first
//   - cond_holds: evaluates a condition code against stored flags
package control_unit_pkg;

  typedef enum logic [1:0] {
    OP_DP     = 2'b00,
    OP_MEM    = 2'b01,
    OP_BRANCH = 2'b10,
    OP_NONE   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_e;

  typedef enum logic [1:0] {
    IMM_8    = 2'b00,
    IMM_12   = 2'b01,
    IMM_24   = 2'b10,
    IMM_RSVD = 2'b11
  } imm_src_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Data-processing command field Funct[4:1]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Writing this register redirects the PC
  localparam logic [3:0] REG_PC = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_holds(cond_e cond, flags_t f);
    logic ok;
    case (cond)
      COND_EQ: ok = f.z;
      COND_NE: ok = !f.z;
      COND_CS: ok = f.c;
      COND_CC: ok = !f.c;
      COND_MI: ok = f.n;
      COND_PL: ok = !f.n;
      COND_VS: ok = f.v;
      COND_VC: ok = !f.v;
      COND_HI: ok = f.c && !f.z;
      COND_LS: ok = !f.c || f.z;
      COND_GE: ok = (f.n == f.v);
      COND_LT: ok = (f.n != f.v);
      COND_GT: ok = !f.z && (f.n == f.v);
      COND_LE: ok = f.z || (f.n != f.v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;  // NV: never executes
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/control_unit_cond_logic.sv
// Condition-code evaluation and the NZCV flag register.
// Ports:
//   CLK        in  clock; flags captured on rising edge
//   reset      in  asynchronous active-low; clears flags
//   cond       in  condition code of current instruction
//   alu_flags  in  {N,Z,C,V} from the ALU this cycle
//   flag_w     in  {NZ, CV} flag-write requests
//   reg_w      in  ungated register write request
//   mem_w      in  ungated memory write request
//   pcs        in  ungated PC-from-result request
//   reg_write  out gated register write enable
//   mem_write  out gated memory write enable
//   pc_src     out gated PC select
module control_unit_cond_logic
  import control_unit_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  cond_e      cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       pcs,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_src
);

  logic [3:0] flags;  // {N,Z,C,V}
  logic       cond_ex;

  // Evaluated on the flags held before the edge that may update them
  assign cond_ex = cond_holds(cond, flags_t'(flags));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

  assign reg_write = reg_w && cond_ex;
  assign mem_write = mem_w && cond_ex;
  assign pc_src    = pcs   && cond_ex;

endmodule

// File: rtl/control_unit_decoder.sv
// Main and ALU decode for the ARM-subset control unit. Purely combinational.
// Ports:
//   op          in  instruction class
//   funct       in  Instr[25:20]
//   rd          in  destination register Instr[15:12]
//   reg_w       out ungated register write request
//   mem_w       out ungated memory write request
//   mem_to_reg  out writeback from memory
//   alu_src     out immediate operand B
//   imm_src     out extend select
//   alu_control out ALU operation
//   flag_w      out {NZ, CV} flag-write requests (ungated)
//   pcs         out ungated PC-from-result request
module control_unit_decoder
  import control_unit_pkg::*;
(
  input  op_e         op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rd,
  output logic        reg_w,
  output logic        mem_w,
  output logic        mem_to_reg,
  output logic        alu_src,
  output imm_src_e    imm_src,
  output alu_ctl_e    alu_control,
  output logic [1:0]  flag_w,
  output logic        pcs
);

  logic branch;
  logic alu_op;

  // Main decode
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_8;
    branch     = 1'b0;
    alu_op     = 1'b0;
    case (op)
      OP_DP: begin
        reg_w   = 1'b1;
        alu_src = funct[5];  // I bit selects immediate operand
        alu_op  = 1'b1;
      end
      OP_MEM: begin
        imm_src = IMM_12;
        alu_src = 1'b1;
        if (funct[0]) begin  // L bit: load
          reg_w      = 1'b1;
          mem_to_reg = 1'b1;
        end else begin
          mem_w = 1'b1;
        end
      end
      OP_BRANCH: begin
        imm_src = IMM_24;
        alu_src = 1'b1;
        branch  = 1'b1;
      end
      default: ;  // OP_NONE: everything stays low
    endcase
  end

  // ALU decode
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        default: alu_control = ALU_ADD;
      endcase
      // S bit requests NZ; C and V are only meaningful for arithmetic ops
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] && (alu_control == ALU_ADD || alu_control == ALU_SUB);
    end
  end

  assign pcs = branch || (reg_w && rd == REG_PC);

endmodule

// File: rtl/control_unit.sv
// Single-cycle ARM-subset control unit: decodes Instr[31:12] into datapath
// controls and gates side effects with the ARM condition code against an
// internal NZCV register. All outputs are combinational.
// Ports:
//   CLK        in  clock
//   reset      in  asynchronous active-low; clears flags
//   Instr      in  Instr[31:12]
//   ALUFlags   in  {N,Z,C,V} from the ALU
//   RegSrc     in  datapath register-source select; passes by, unused here
//   RegWrite   out register-file write enable (gated)
//   ImmSrc     out extend select
//   ALUSrc     out immediate operand B
//   ALUControl out ALU operation
//   MemWrite   out data-memory write enable (gated)
//   MemtoReg   out writeback from memory
//   PCSrc      out PC from result (gated)
module control_unit
  import control_unit_pkg::*;
(
  input  logic         CLK,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic [1:0]   RegSrc,
  output logic         RegWrite,
  output logic [1:0]   ImmSrc,
  output logic         ALUSrc,
  output logic [1:0]   ALUControl,
  output logic         MemWrite,
  output logic         MemtoReg,
  output logic         PCSrc
);

  logic       reg_w, mem_w, pcs;
  logic [1:0] flag_w;
  imm_src_e   imm_src;
  alu_ctl_e   alu_control;

  // RegSrc and Rn are datapath-only; they must not influence control
  logic unused_bits;
  assign unused_bits = ^{RegSrc, Instr[19:16]};

  control_unit_decoder u_dec (
    .op          (op_e'(Instr[27:26])),
    .funct       (Instr[25:20]),
    .rd          (Instr[15:12]),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .mem_to_reg  (MemtoReg),
    .alu_src     (ALUSrc),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .flag_w      (flag_w),
    .pcs         (pcs)
  );

  control_unit_cond_logic u_cond (
    .CLK       (CLK),
    .reset     (reset),
    .cond      (cond_e'(Instr[31:28])),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pcs       (pcs),
    .reg_write (RegWrite),
    .mem_write (MemWrite),
    .pc_src    (PCSrc)
  );

  assign ImmSrc     = imm_src;
  assign ALUControl = alu_control;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process computes expected
// outputs from a behavioural model and queues them; a monitor on the falling
// edge pops and compares.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite, ALUSrc, MemWrite, MemtoReg, PCSrc;
  logic [1:0]  ImmSrc, ALUControl;

  control_unit dut (
    .CLK        (CLK),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rw;
    logic [1:0] imm;
    logic       asrc;
    logic [1:0] actl;
    logic       mw;
    logic       m2r;
    logic       pcs;
    logic [3:0] fl;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] mflags;  // model of the stored NZCV

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition codes come in true/inverted pairs; 1110 is always, 1111 never.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c[0]) return (c[3:1] == 3'd7) ? 1'b0 : ~base;
    return base;
  endfunction

  function automatic logic [1:0] dp_aluctl(input logic [5:0] fn);
    logic [3:0] cmd;
    cmd = fn[4:1];
    if (cmd == 4'd4)  return 2'd0;
    if (cmd == 4'd2)  return 2'd1;
    if (cmd == 4'd0)  return 2'd2;
    if (cmd == 4'd12) return 2'd3;
    return 2'd0;
  endfunction

  function automatic exp_t model(input logic [19:0] ins, input logic [3:0] f);
    exp_t e;
    logic [1:0] op;
    logic [5:0] fn;
    logic regw, memw, br, ok;
    op = ins[15:14];
    fn = ins[13:8];
    ok = cond_ok(ins[19:16], f);
    regw = 0; memw = 0; br = 0;
    e.imm = 0; e.asrc = 0; e.actl = 0; e.m2r = 0;
    if (op == 2'd0) begin
      regw = 1; e.asrc = fn[5]; e.actl = dp_aluctl(fn);
    end else if (op == 2'd1) begin
      e.imm = 2'd1; e.asrc = 1;
      if (fn[0]) begin regw = 1; e.m2r = 1; end
      else memw = 1;
    end else if (op == 2'd2) begin
      e.imm = 2'd2; e.asrc = 1; br = 1;
    end
    e.rw  = regw & ok;
    e.mw  = memw & ok;
    e.pcs = (br | (regw && ins[3:0] == 4'hF)) & ok;
    e.fl  = f;
    return e;
  endfunction

  function automatic logic [3:0] next_flags(input logic [19:0] ins, input logic [3:0] af,
                                            input logic [3:0] f);
    logic [3:0] nf;
    nf = f;
    if (ins[15:14] == 2'd0 && ins[8] && cond_ok(ins[19:16], f)) begin
      nf[3:2] = af[3:2];
      if (dp_aluctl(ins[13:8]) < 2'd2) nf[1:0] = af[1:0];
    end
    return nf;
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] fn, input logic [3:0] rd);
    return {c, op, fn, 4'h0, rd};
  endfunction

  // Called at posedge+1: drive, queue expectation, advance to next posedge+1.
  task automatic step(input logic [19:0] ins, input logic [3:0] af, input logic rst_mid);
    exp_t       e;
    logic [3:0] nf;
    Instr    = ins;
    ALUFlags = af;
    RegSrc   = 2'($urandom);
    if (rst_mid) begin
      #1;
      reset  = 1'b0;
      mflags = 4'h0;
    end
    e  = model(ins, mflags);
    sb.push_back(e);
    nf = next_flags(ins, af, mflags);
    @(posedge CLK);
    mflags = reset ? nf : 4'h0;
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("RegWrite",   {3'b0, RegWrite}, {3'b0, e.rw});
        check("ImmSrc",     {2'b0, ImmSrc},   {2'b0, e.imm});
        check("ALUSrc",     {3'b0, ALUSrc},   {3'b0, e.asrc});
        check("ALUControl", {2'b0, ALUControl}, {2'b0, e.actl});
        check("MemWrite",   {3'b0, MemWrite}, {3'b0, e.mw});
        check("MemtoReg",   {3'b0, MemtoReg}, {3'b0, e.m2r});
        check("PCSrc",      {3'b0, PCSrc},    {3'b0, e.pcs});
        check("flags",      dut.u_cond.flags, e.fl);
      end
    end
  end

  initial begin
    int guard;
    reset    = 1'b0;
    Instr    = '0;
    ALUFlags = '0;
    RegSrc   = '0;
    mflags   = 4'h0;
    @(posedge CLK);
    #1;
    // In reset: Instr=0 gives ANDEQ, fails on Z=0; flag writes ignored
    step(20'h0, 4'hF, 1'b0);
    step(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'hF, 1'b0);
    reset = 1'b1;
    step(20'h0, 4'h0, 1'b0);

    // ADDS imm, then ADDEQ succeeds on Z=1
    step(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'b0100, 1'b0);
    step(mk(4'h0, 2'b00, 6'b001000, 4'h2), 4'b0000, 1'b0);
    // STR, LDR
    step(mk(4'hE, 2'b01, 6'b011000, 4'h3), 4'h0, 1'b0);
    step(mk(4'hE, 2'b01, 6'b011001, 4'h3), 4'h0, 1'b0);
    // B, BNE with Z=1, never-condition on each class
    step(mk(4'hE, 2'b10, 6'b000000, 4'h0), 4'h0, 1'b0);
    step(mk(4'h1, 2'b10, 6'b000000, 4'h0), 4'h0, 1'b0);
    step(mk(4'hF, 2'b10, 6'b000000, 4'h0), 4'h0, 1'b0);
    step(mk(4'hF, 2'b01, 6'b011000, 4'h0), 4'h0, 1'b0);
    step(mk(4'hF, 2'b00, 6'b101001, 4'hF), 4'hF, 1'b0);
    // DP writing R15
    step(mk(4'hE, 2'b00, 6'b001000, 4'hF), 4'h0, 1'b0);
    // SUBS updates NZCV, ANDS only NZ, ORR reg
    step(mk(4'hE, 2'b00, 6'b000101, 4'h4), 4'b1001, 1'b0);
    step(mk(4'hE, 2'b00, 6'b000001, 4'h4), 4'b0110, 1'b0);
    step(mk(4'hE, 2'b00, 6'b011000, 4'h4), 4'b0000, 1'b0);
    // Op=11 does nothing
    step(mk(4'hE, 2'b11, 6'b111111, 4'hF), 4'hF, 1'b0);
    // Load 1111, then reset mid-cycle
    step(mk(4'hE, 2'b00, 6'b000101, 4'h4), 4'hF, 1'b0);
    step(mk(4'hE, 2'b00, 6'b001000, 4'h1), 4'h0, 1'b1);
    step(mk(4'hE, 2'b00, 6'b001001, 4'h1), 4'hF, 1'b0);
    reset = 1'b1;
    step(mk(4'h0, 2'b00, 6'b001000, 4'h1), 4'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c, rd;
      c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      step({c, 2'($urandom), 6'($urandom), 4'($urandom), rd}, 4'($urandom), 1'b0);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
